// File: rtl/fpmult_round_pipe.sv
// Round/pack stage for the FP multiplier: applies the rounding mode, then
// post-normalises, saturates or flushes, and packs {sign, exp, frac} with flags.
// Two register stages share one advance enable, so the pipe stalls as a unit.
module fpmult_round_pipe #(
  parameter int unsigned EW = 8,
  parameter int unsigned MW = 23
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic [EW+1:0]    in_e,
  input  logic [MW:0]      in_m,
  input  logic             in_g,
  input  logic             in_st,
  input  logic [1:0]       in_mode,
  input  logic [4:0]       in_exc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [EW+MW:0]   out_z,
  output logic [4:0]       out_flags
);

  localparam int unsigned MRW = MW + 2;
  localparam int unsigned EXW = EW + 2;
  localparam int unsigned EPW = EW + 3;
  localparam int unsigned ZW  = 1 + EW + MW;

  localparam logic [1:0] MODE_RNE = 2'b00;
  localparam logic [1:0] MODE_RTZ = 2'b01;
  localparam logic [1:0] MODE_RUP = 2'b10;
  localparam logic [1:0] MODE_RDN = 2'b11;

  localparam logic signed [EPW-1:0] EXP_MAX  = EPW'((2 ** EW) - 1);
  localparam logic signed [EPW-1:0] EXP_ZERO = '0;
  localparam logic [EW-1:0] EXP_ONES   = '1;
  localparam logic [EW-1:0] EXP_MAXFIN = {{(EW-1){1'b1}}, 1'b0};
  localparam logic [MW-1:0] FRAC_ONES  = '1;
  localparam logic [MW-1:0] FRAC_ZERO  = '0;
  localparam logic [MW-1:0] QNAN_FRAC  = {1'b1, {(MW-1){1'b0}}};

  // Stage 1 state
  logic           s1_valid;
  logic           s1_sign;
  logic [EXW-1:0] s1_e;
  logic [MRW-1:0] s1_mr;
  logic [1:0]     s1_mode;
  logic           s1_inexact;
  logic           s1_nan;
  logic           s1_inf;

  // Combinational intermediates
  logic           en;
  logic           round_up;
  logic           inexact_c;
  logic [MRW-1:0] mr_c;
  logic           carry;
  logic signed [EPW-1:0] ep_c;
  logic [MW-1:0]  frac_c;
  logic           ovf_c;
  logic           unf_c;
  logic           ovf_inf_c;
  logic [ZW-1:0]  z_c;
  logic [4:0]     flags_c;
  logic           unused_exc;

  // Whole pipe advances whenever the output register is free or being drained
  assign en         = !out_valid | out_ready;
  assign in_ready   = en;
  assign unused_exc = ^in_exc[2:0];

  // Rounding decision and mantissa increment
  always_comb begin
    inexact_c = in_g | in_st;
    round_up  = 1'b0;
    case (in_mode)
      MODE_RNE: round_up = in_g & (in_st | in_m[0]);
      MODE_RTZ: round_up = 1'b0;
      MODE_RUP: round_up = !in_sign & inexact_c;
      MODE_RDN: round_up = in_sign & inexact_c;
      default:  round_up = 1'b0;
    endcase
    mr_c = MRW'(in_m) + MRW'(round_up);
  end

  // Stage 1 register: rounded mantissa plus side-band fields
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s1_sign    <= 1'b0;
      s1_e       <= '0;
      s1_mr      <= '0;
      s1_mode    <= '0;
      s1_inexact <= 1'b0;
      s1_nan     <= 1'b0;
      s1_inf     <= 1'b0;
    end else if (en) begin
      s1_valid   <= in_valid;
      s1_sign    <= in_sign;
      s1_e       <= in_e;
      s1_mr      <= mr_c;
      s1_mode    <= in_mode;
      s1_inexact <= inexact_c;
      s1_nan     <= in_exc[4];
      s1_inf     <= in_exc[3];
    end
  end

  // Post-normalise, range check and pack with exception priority
  always_comb begin
    carry     = s1_mr[MW+1];
    frac_c    = carry ? s1_mr[MW:1] : s1_mr[MW-1:0];
    ep_c      = {s1_e[EXW-1], s1_e} + EPW'(carry);
    ovf_c     = (ep_c >= EXP_MAX);
    unf_c     = (ep_c <= EXP_ZERO);
    ovf_inf_c = (s1_mode == MODE_RNE) |
                ((s1_mode == MODE_RUP) & !s1_sign) |
                ((s1_mode == MODE_RDN) & s1_sign);
    z_c       = {s1_sign, ep_c[EW-1:0], frac_c};
    flags_c   = {4'b0000, s1_inexact};
    if (s1_nan) begin
      z_c     = {1'b0, EXP_ONES, QNAN_FRAC};
      flags_c = {s1_nan, s1_inf, 3'b000};
    end else if (s1_inf) begin
      z_c     = {s1_sign, EXP_ONES, FRAC_ZERO};
      flags_c = {1'b0, s1_inf, 3'b000};
    end else if (ovf_c) begin
      z_c     = ovf_inf_c ? {s1_sign, EXP_ONES, FRAC_ZERO}
                          : {s1_sign, EXP_MAXFIN, FRAC_ONES};
      flags_c = 5'b00101;
    end else if (unf_c) begin
      z_c     = {s1_sign, (ZW-1)'(0)};
      flags_c = 5'b00011;
    end
  end

  // Output register; holds while downstream stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_z     <= '0;
      out_flags <= '0;
    end else if (en) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_z     <= z_c;
        out_flags <= flags_c;
      end
    end
  end

endmodule

// File: tb/tb_fpmult_round_pipe.sv
// Self-checking bench for fpmult_round_pipe (EW=8, MW=23): directed corner
// vectors, randomized beats against an arithmetic reference, stall and reset.
module tb_fpmult_round_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [9:0]  in_e;
  logic [23:0] in_m;
  logic        in_g;
  logic        in_st;
  logic [1:0]  in_mode;
  logic [4:0]  in_exc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_z;
  logic [4:0]  out_flags;

  typedef struct packed {
    logic [31:0] z;
    logic [4:0]  f;
  } exp_t;

  exp_t q[$];
  int   n_cmp;
  int   n_fail;
  int   n_out;
  bit   rand_done;

  fpmult_round_pipe #(.EW(8), .MW(23)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_e(in_e), .in_m(in_m), .in_g(in_g), .in_st(in_st),
    .in_mode(in_mode), .in_exc(in_exc), .out_valid(out_valid),
    .out_ready(out_ready), .out_z(out_z), .out_flags(out_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Reference: rounding by comparing the dropped quarter-ulp remainder to one half
  function automatic exp_t model(input logic s, input int e, input logic [23:0] m,
                                 input logic g, input logic st, input logic [1:0] mode,
                                 input logic [4:0] exc);
    exp_t r;
    int rem, mant, ee, frac;
    bit up, inexact, to_inf;
    rem = (g ? 2 : 0) + (st ? 1 : 0);
    inexact = (rem != 0);
    mant = int'(m);
    case (mode)
      2'd0: up = (rem > 2) || (rem == 2 && (mant % 2) == 1);
      2'd1: up = 0;
      2'd2: up = inexact && !s;
      default: up = inexact && s;
    endcase
    mant = mant + (up ? 1 : 0);
    ee = e;
    if (mant >= (1 << 24)) begin
      mant = mant / 2;
      ee = ee + 1;
    end
    frac = mant - (1 << 23);
    to_inf = (mode == 2'd0) || (mode == 2'd2 && !s) || (mode == 2'd3 && s);
    if (exc[4]) begin
      r.z = 32'h7FC00000;
      r.f = {1'b1, exc[3], 3'b000};
    end else if (exc[3]) begin
      r.z = {s, 31'h7F800000};
      r.f = 5'b01000;
    end else if (ee >= 255) begin
      r.z = to_inf ? {s, 31'h7F800000} : {s, 31'h7F7FFFFF};
      r.f = 5'b00101;
    end else if (ee <= 0) begin
      r.z = {s, 31'h0};
      r.f = 5'b00011;
    end else begin
      r.z = {s, 8'(ee), 23'(frac)};
      r.f = {4'b0000, inexact};
    end
    return r;
  endfunction

  // Offer one beat; record its expected result when the handshake will happen
  task automatic send(input logic s, input int e, input logic [23:0] m, input logic g,
                      input logic st, input logic [1:0] mode, input logic [4:0] exc,
                      input exp_t ex);
    bit acc;
    acc = 0;
    in_valid = 1'b1; in_sign = s; in_e = 10'(e); in_m = m;
    in_g = g; in_st = st; in_mode = mode; in_exc = exc;
    for (int i = 0; i < 300 && !acc; i++) begin
      @(negedge clk);
      if (in_ready) begin
        q.push_back(ex);
        acc = 1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!acc) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_dir(input logic s, input int e, input logic [23:0] m, input logic g,
                          input logic st, input logic [1:0] mode, input logic [4:0] exc,
                          input logic [31:0] z, input logic [4:0] f);
    exp_t ex;
    ex.z = z;
    ex.f = f;
    send(s, e, m, g, st, mode, exc, ex);
  endtask

  task automatic send_rand();
    logic s, g, st;
    logic [1:0] mode;
    logic [4:0] exc;
    logic [23:0] m;
    int e, r;
    int edges[7] = '{0, -1, 255, 254, 1, 300, -200};
    s = 1'($urandom); g = 1'($urandom); st = 1'($urandom); mode = 2'($urandom);
    m = {1'b1, 23'($urandom)};
    if ($urandom % 8 == 0) m = 24'hFFFFFF;
    r = int'($urandom % 8);
    e = (r == 0) ? edges[$urandom % 7] : int'($urandom_range(1, 254));
    r = int'($urandom % 16);
    exc = (r == 0) ? 5'b10000 : (r == 1) ? 5'b01000 : {2'b00, 3'($urandom)};
    send(s, e, m, g, st, mode, exc, model(s, e, m, g, st, mode, exc));
  endtask

  task automatic drain();
    for (int i = 0; i < 500 && q.size() != 0; i++) @(posedge clk);
    #1;
    chk("drain_left", 32'(q.size()), 32'd0);
  endtask

  // Scoreboard: compare every emitted result with the oldest expectation
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      n_out++;
      if (q.size() == 0) begin
        chk("unexpected_out", 32'd1, 32'd0);
      end else begin
        chk($sformatf("z#%0d", n_out), out_z, q[0].z);
        chk($sformatf("flags#%0d", n_out), 32'(out_flags), 32'(q[0].f));
        void'(q.pop_front());
      end
    end
  end

  initial begin
    n_cmp = 0; n_fail = 0; n_out = 0; rand_done = 0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_sign = 0; in_e = '0; in_m = '0; in_g = 0; in_st = 0; in_mode = '0; in_exc = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_z", out_z, 32'd0);
    chk("rst_out_flags", 32'(out_flags), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    // Latency: valid two edges after acceptance
    send_dir(0, 127, 24'h800000, 1, 0, 2'd0, 5'b0, 32'h3F800000, 5'b00001);
    chk("lat_edge1", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    chk("lat_edge2", 32'(out_valid), 32'd1);
    drain();

    // Directed corners
    send_dir(0, 127, 24'hFFFFFF, 1, 1, 2'd0, 5'b0, 32'h40000000, 5'b00001);
    send_dir(0, 254, 24'hFFFFFF, 1, 1, 2'd0, 5'b0, 32'h7F800000, 5'b00101);
    send_dir(0, 254, 24'hFFFFFF, 1, 1, 2'd1, 5'b0, 32'h7F7FFFFF, 5'b00001);
    send_dir(0, 254, 24'hFFFFFF, 1, 1, 2'd3, 5'b0, 32'h7F7FFFFF, 5'b00001);
    send_dir(0, 254, 24'hFFFFFF, 1, 1, 2'd2, 5'b0, 32'h7F800000, 5'b00101);
    send_dir(1, 254, 24'hFFFFFF, 1, 1, 2'd3, 5'b0, 32'hFF800000, 5'b00101);
    send_dir(1, 254, 24'hFFFFFF, 1, 1, 2'd2, 5'b0, 32'hFF7FFFFF, 5'b00001);
    send_dir(0, 300, 24'h800000, 0, 0, 2'd1, 5'b0, 32'h7F7FFFFF, 5'b00101);
    send_dir(0, 255, 24'h800000, 0, 0, 2'd0, 5'b0, 32'h7F800000, 5'b00101);
    send_dir(1, 0, 24'h800000, 0, 0, 2'd0, 5'b0, 32'h80000000, 5'b00011);
    send_dir(0, -5, 24'hC00000, 1, 0, 2'd2, 5'b0, 32'h00000000, 5'b00011);
    send_dir(0, 1, 24'h800000, 0, 0, 2'd0, 5'b0, 32'h00800000, 5'b00000);
    send_dir(0, 127, 24'h800001, 1, 0, 2'd0, 5'b0, 32'h3F800002, 5'b00001);
    send_dir(0, 77, 24'h123456, 1, 1, 2'd0, 5'b10000, 32'h7FC00000, 5'b10000);
    send_dir(1, 77, 24'h123456, 0, 0, 2'd0, 5'b01000, 32'hFF800000, 5'b01000);
    send_dir(1, 300, 24'hFFFFFF, 1, 1, 2'd1, 5'b11000, 32'h7FC00000, 5'b11000);
    drain();

    // Randomized beats with random backpressure
    fork
      begin
        for (int i = 0; i < 300; i++) send_rand();
        rand_done = 1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom % 4) != 0;
        end
      end
    join
    out_ready = 1'b1;
    drain();

    // Stall: four beats offered with the output blocked
    out_ready = 1'b0;
    fork
      begin
        send_dir(0, 100, 24'h800000, 0, 0, 2'd0, 5'b0, 32'h32000000, 5'b00000);
        send_dir(1, 101, 24'hA00000, 0, 1, 2'd1, 5'b0, 32'hB2A00000, 5'b00001);
        send_dir(0, 102, 24'hC00000, 1, 1, 2'd2, 5'b0, 32'h33400001, 5'b00001);
        send_dir(1, 103, 24'hE00000, 1, 0, 2'd3, 5'b0, 32'hB3E00001, 5'b00001);
      end
      begin
        repeat (3) @(posedge clk);
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          chk("stall_in_ready", 32'(in_ready), 32'd0);
          chk("stall_out_valid", 32'(out_valid), 32'd1);
          chk("stall_out_z", out_z, (q.size() != 0) ? q[0].z : 32'hDEADBEEF);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with two beats in flight: both must vanish
    out_ready = 1'b0;
    send_dir(0, 110, 24'h900000, 0, 0, 2'd0, 5'b0, 32'h37100000, 5'b00000);
    send_dir(0, 111, 24'h910000, 0, 0, 2'd0, 5'b0, 32'h37910000, 5'b00000);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    q.delete();
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("flush_no_emit", 32'(out_valid), 32'd0);
    end

    // Pipe still works after the flush
    send_dir(0, 127, 24'h800000, 1, 0, 2'd0, 5'b0, 32'h3F800000, 5'b00001);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
